pmswitch_ack_collector: RTL

- Downstream consumer of the PM switch 48-bit metadata word: {ackCount[47:40], PMSwitchOPS[39:32], hashedAddress[31:0]}.
- Holds up to DEPTH outstanding requests and counts ack beats against each hashedAddress.
- When a request's ack count reaches zero, it emits a completion beat (op + address) on an AXI-stream master.
- Sits between the PM switch metadata path and the host completion/response logic.

---
 rtl/pmswitch_ack_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pmswitch_ack_collector.sv
// rtl/pmswitch_ack_collector.sv - outstanding-request table that counts acks and emits completions
module pmswitch_ack_collector #(
    parameter int DEPTH = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [47:0]                s_meta_tdata,
    input  logic                       s_meta_tvalid,
    output logic                       s_meta_tready,
    input  logic [31:0]                s_ack_tdata,
    input  logic                       s_ack_tvalid,
    output logic                       s_ack_tready,
    output logic [39:0]                m_done_tdata,
    output logic                       m_done_tvalid,
    input  logic                       m_done_tready,
    output logic [$clog2(DEPTH+1)-1:0] pending_count,
    output logic                       err_unmatched
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_nxt;
    logic [31:0]      addr_q [DEPTH];
    logic [7:0]       op_q   [DEPTH];
    logic [7:0]       rem_q  [DEPTH];

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          ack_hit;
    logic [IW-1:0] ack_idx;
    logic          done_found;
    logic [IW-1:0] done_idx;
    logic          meta_acc;
    logic          load;
    logic          done_take;
    logic [CW-1:0] cnt_nxt;

    // Acks are never back-pressured; both readies drop while reset is held.
    assign s_ack_tready  = aresetn;
    assign s_meta_tready = aresetn & free_found;
    assign meta_acc      = s_meta_tvalid & s_meta_tready;
    assign load          = !m_done_tvalid || m_done_tready;
    assign done_take     = load & done_found;

    // Lowest-index searches over pre-edge state: free slot, ack match, done entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        ack_hit    = 1'b0;
        ack_idx    = '0;
        done_found = 1'b0;
        done_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (s_ack_tvalid && valid_q[i] && addr_q[i] == s_ack_tdata && rem_q[i] != 8'd0) begin
                ack_hit = 1'b1;
                ack_idx = IW'(i);
            end
            if (valid_q[i] && rem_q[i] == 8'd0) begin
                done_found = 1'b1;
                done_idx   = IW'(i);
            end
        end
    end

    // Next valid vector and its popcount, so pending_count tracks the table exactly.
    always_comb begin
        valid_nxt = valid_q;
        if (done_take) begin
            valid_nxt[done_idx] = 1'b0;
        end
        if (meta_acc) begin
            valid_nxt[free_idx] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(valid_nxt[i]);
        end
    end

    // Table fields: a new request lands in the free slot, a matched ack decrements its entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                op_q[i]   <= '0;
                rem_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (meta_acc && free_idx == IW'(i)) begin
                    addr_q[i] <= s_meta_tdata[31:0];
                    op_q[i]   <= s_meta_tdata[39:32];
                    rem_q[i]  <= s_meta_tdata[47:40];
                end else if (ack_hit && ack_idx == IW'(i)) begin
                    rem_q[i] <= rem_q[i] - 8'd1;
                end
            end
        end
    end

    // Valid bits, occupancy count and the unmatched-ack pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q       <= '0;
            pending_count <= '0;
            err_unmatched <= 1'b0;
        end else begin
            valid_q       <= valid_nxt;
            pending_count <= cnt_nxt;
            err_unmatched <= s_ack_tvalid & !ack_hit;
        end
    end

    // Single output slot: refilled from the lowest done entry whenever it is empty or consumed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_done_tdata  <= '0;
            m_done_tvalid <= 1'b0;
        end else if (load) begin
            if (done_found) begin
                m_done_tdata  <= {op_q[done_idx], addr_q[done_idx]};
                m_done_tvalid <= 1'b1;
            end else begin
                m_done_tvalid <= 1'b0;
            end
        end
    end

endmodule
